if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the IF/ID pipeline register.
- Fetches sequential words from a handshaked (variable-latency) instruction memory and buffers them in a small FIFO.
- Presents one instruction per cycle, with its PC and PC+4, to decode.
- Supports decode back-pressure (Stall) and branch/jump redirection (flush plus restart at a new PC).

Parameters:
DEPTH, 4, number of queue entries (power of 2, >=2)
RESET_PC, 32'h00000000, fetch address after reset

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  asynchronous, active-high reset
Redirect  input  1  flush queue and restart fetch at RedirectPC
RedirectPC  input  32  new fetch target; bits [1:0] ignored (treated as 0)
Stall  input  1  decode cannot accept this cycle
IMemReq  output  1  fetch request to instruction memory
IMemAddr  output  32  word-aligned fetch address
IMemAck  input  1  memory accepted request; IMemData valid this cycle
IMemData  input  32  instruction word returned with IMemAck
InstrValid  output  1  head entry valid
Instruction  output  32  head instruction; 32'h00000000 (NOP) when empty
PCResult  output  32  PC of head instruction; 0 when empty
PCAddResult  output  32  PCResult + 4; 0 when empty
Count  output  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, Rst=1): FetchPC=RESET_PC, rd/wr pointers=0, Count=0, InstrValid=0, Instruction/PCResult/PCAddResult=0, IMemReq=0. Rst dominates Redirect.
- State: FetchPC register, circular buffer of DEPTH entries {pc[31:0], instr[31:0]}, rd/wr pointers with extra wrap bit.
- IMemAddr = {FetchPC[31:2],2'b00} at all times.
- IMemReq = (Count < DEPTH) && !Redirect. Combinational; address stable while request held.
- Memory handshake:
  - A transfer occurs when IMemReq && IMemAck.
  - Data is captured that edge: push {FetchPC, IMemData}, then FetchPC += 4 (mod 2^32, wraps 32'hFFFFFFFC→0).
  - IMemAck without IMemReq is ignored.
  - Memory may hold IMemAck low for any number of cycles; IMemReq and address remain asserted and stable meanwhile, unless Redirect fires.
- Pop: occurs when InstrValid && !Stall; advance rd pointer at the edge.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Latency: word acked at edge N appears as head no earlier than after edge N (InstrValid high cycle N+1 if queue was empty). No combinational bypass from IMemData to Instruction.
- Full (Count==DEPTH): IMemReq=0 even if a pop occurs the same cycle; fetch resumes the following cycle.
- Empty: InstrValid=0 and outputs are zero; Stall has no effect.
- Head outputs are driven combinationally from the entry at rd pointer. PCAddResult = head pc + 4.
- Redirect (synchronous, priority over push/pop):
  - At the edge: rd=wr=0, Count=0, FetchPC={RedirectPC[31:2],2'b00}.
  - Any IMemAck in that cycle is discarded; IMemReq is 0 in that cycle, so no transfer occurs.
  - Any pop that cycle is void.
  - First fetch of the target is requested the next cycle.
- Redirect held multiple cycles: queue stays empty, FetchPC follows RedirectPC each cycle.
- Stall has no effect on fetching; the queue fills to DEPTH, then requests stop.
- Count never exceeds DEPTH or underflows. A violation is a design bug, to be covered by assertion.

Test Plan:
- Reset release, IMemAck tied 1, Stall=0 → IMemAddr 0x0,0x4,0x8… on consecutive cycles; InstrValid rises one cycle after first ack; PCResult=0x0, PCAddResult=0x4, Instruction=data for 0x0; then one instruction per cycle.
- IMemAck=1, Stall=1 held 10 cycles → Count reaches 4, IMemReq drops, FetchPC=0x10. Release Stall → heads 0x0,0x4,0x8,0xC in order; fetch resumes at 0x10 one cycle after first pop.
- Memory with 3-cycle ack latency → IMemAddr held constant across the wait; only one push per ack; InstrValid gaps match latency; no duplicated or skipped PCs.
- Redirect=1 with RedirectPC=0x0000_0103 while Count=3 and IMemAck=1 same cycle → next cycle Count=0, InstrValid=0, IMemAddr=0x100. Acked word dropped; next head PCResult=0x100.
- RESET_PC=32'hFFFF_FFF8, always ack → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; PCAddResult of 0xFFFF_FFFC equals 0.
- Assert Rst mid-operation with Count=2 and Redirect=1 → outputs zero immediately (async), FetchPC=RESET_PC, Redirect ignored.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Fetch-front-end bundle: instruction memory handshake, redirect/stall from the pipeline,
// and the head-of-queue outputs presented to decode.
interface if_prefetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Redirect;
    logic [31:0]   RedirectPC;
    logic          Stall;
    logic          IMemReq;
    logic [31:0]   IMemAddr;
    logic          IMemAck;
    logic [31:0]   IMemData;
    logic          InstrValid;
    logic [31:0]   Instruction;
    logic [31:0]   PCResult;
    logic [31:0]   PCAddResult;
    logic [CW-1:0] Count;

    modport slave (
        input  Redirect, RedirectPC, Stall, IMemAck, IMemData,
        output IMemReq, IMemAddr, InstrValid, Instruction, PCResult, PCAddResult, Count
    );

    modport master (
        output Redirect, RedirectPC, Stall, IMemAck, IMemData,
        input  IMemReq, IMemAddr, InstrValid, Instruction, PCResult, PCAddResult, Count
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID; word acked at edge N is head from cycle N+1.
// Decode stall holds the head; fetch stops only when the queue is full; redirect flushes.
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                Clk,
    input  logic                Rst,
    if_prefetch_queue_if.slave  bus
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW:0]    FULL = (AW + 1)'(DEPTH);

    logic [31:0] fetch_pc;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr;
    logic [AW:0] count;
    logic [31:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];

    logic full;
    logic empty;
    logic req;
    logic push;
    logic pop;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL);
    assign empty = (count == '0);
    // Requests drop during reset and during a redirect so no stale word is ever captured.
    assign req   = !Rst && !full && !bus.Redirect;
    assign push  = req && bus.IMemAck;
    assign pop   = !empty && !bus.Stall;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetch_pc <= RESET_PC & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (bus.Redirect) begin
            fetch_pc <= bus.RedirectPC & ~32'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between rd_ptr and wr_ptr.
    always_ff @(posedge Clk) begin
        if (push) begin
            pc_q[wr_ptr[AW-1:0]]    <= fetch_pc;
            instr_q[wr_ptr[AW-1:0]] <= bus.IMemData;
        end
    end

    assign bus.IMemReq     = req;
    assign bus.IMemAddr    = fetch_pc;
    assign bus.Count       = count;
    assign bus.InstrValid  = !empty;
    assign bus.Instruction = empty ? 32'h0 : instr_q[rd_ptr[AW-1:0]];
    assign bus.PCResult    = empty ? 32'h0 : pc_q[rd_ptr[AW-1:0]];
    assign bus.PCAddResult = empty ? 32'h0 : pc_q[rd_ptr[AW-1:0]] + 32'd4;

    a_count_bound : assert property (@(posedge Clk) disable iff (Rst) count <= FULL);
    a_no_push_full : assert property (@(posedge Clk) disable iff (Rst) !(push && full));
endmodule
